// File: rtl/hazard_pkg.sv
// ----------------------------------------------------------------------------
// hazard_pkg
// Shared types for the pipeline hazard controller:
//   fwd_sel_t   - EX operand source select (register file, WB, MEM)
//   hz_state_t  - data-cache miss FSM states
//   dst_tag_t   - destination part of a stage tag (rd, write enable, load flag)
//   stage_tag_t - full EX-stage tag (sources plus destination)
// fwd_select() applies the MEM-over-WB forwarding priority for one operand.
// ----------------------------------------------------------------------------
package hazard_pkg;

   typedef enum logic [1:0] {
      FWD_REG = 2'b00,
      FWD_WB  = 2'b01,
      FWD_MEM = 2'b10
   } fwd_sel_t;

   typedef enum logic {
      RUN  = 1'b0,
      MISS = 1'b1
   } hz_state_t;

   typedef struct packed {
      logic [4:0] rd;
      logic       reg_write;
      logic       is_load;
   } dst_tag_t;

   typedef struct packed {
      logic [4:0] rs1;
      logic [4:0] rs2;
      dst_tag_t   dst;
   } stage_tag_t;

   // The younger producer (MEM) wins over the older one (WB); x0 is never
   // forwarded because it reads as zero regardless of writes.
   function automatic fwd_sel_t fwd_select(input logic [4:0] rs,
                                           input dst_tag_t   m,
                                           input dst_tag_t   w);
      if (m.reg_write && (m.rd != 5'd0) && (m.rd == rs))
         return FWD_MEM;
      if (w.reg_write && (w.rd != 5'd0) && (w.rd == rs))
         return FWD_WB;
      return FWD_REG;
   endfunction

endpackage

// File: rtl/hazard_perf.sv
// ----------------------------------------------------------------------------
// hazard_perf
// Free-running 32-bit event counters for the hazard controller. Each counter
// wraps naturally at 2^32 and clears on reset.
// Ports:
//   clk, rst      - clock, asynchronous active-high reset
//   stall_f       - fetch stall this cycle
//   flush_any     - flushD or flushE this cycle
//   in_miss       - controller FSM is in MISS this cycle
//   stall_cycles  - cycles with stall_f
//   flush_count   - cycles with flush_any
//   miss_cycles   - cycles spent in MISS
// ----------------------------------------------------------------------------
module hazard_perf (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_f,
   input  logic        flush_any,
   input  logic        in_miss,
   output logic [31:0] stall_cycles,
   output logic [31:0] flush_count,
   output logic [31:0] miss_cycles
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cycles <= '0;
         flush_count  <= '0;
         miss_cycles  <= '0;
      end else begin
         if (stall_f)   stall_cycles <= stall_cycles + 32'd1;
         if (flush_any) flush_count  <= flush_count  + 32'd1;
         if (in_miss)   miss_cycles  <= miss_cycles  + 32'd1;
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// ----------------------------------------------------------------------------
// hazard_ctrl
// Hazard unit for a 5-stage in-order pipeline. Keeps shadow register tags for
// the E, M and W stages, produces EX forwarding selects, detects load-use
// hazards and taken branches, and freezes the whole pipeline while the data
// cache services a miss.
// Ports:
//   clk, rst                   - clock, asynchronous active-high reset
//   rs1D, rs2D, rdD            - decode-stage register numbers
//   regWriteD, isLoadD         - decode-stage write enable / load flag
//   branchTakenE               - branch resolved taken in EX
//   memReqM, cacheHitM         - MEM-stage cache access and hit
//   memReadyM                  - refill complete
//   forwardAE, forwardBE       - operand selects: 00 reg, 10 MEM, 01 WB
//   stallF/D/E/M, flushD/E     - pipeline control
// Build option: define HAZARD_PERF_EN to add the 32-bit stallCycles,
// flushCount and missCycles counters (hazard_perf sub-module).
// ----------------------------------------------------------------------------
module hazard_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  rs1D,
   input  logic [4:0]  rs2D,
   input  logic [4:0]  rdD,
   input  logic        regWriteD,
   input  logic        isLoadD,
   input  logic        branchTakenE,
   input  logic        memReqM,
   input  logic        cacheHitM,
   input  logic        memReadyM,
   output logic [1:0]  forwardAE,
   output logic [1:0]  forwardBE,
   output logic        stallF,
   output logic        stallD,
   output logic        stallE,
   output logic        stallM,
   output logic        flushD,
   output logic        flushE
`ifdef HAZARD_PERF_EN
   ,
   output logic [31:0] stallCycles,
   output logic [31:0] flushCount,
   output logic [31:0] missCycles
`endif
);

   import hazard_pkg::*;

   hz_state_t  state;
   stage_tag_t tag_e;
   dst_tag_t   tag_m;
   dst_tag_t   tag_w;

   logic miss_start;
   logic freeze;
   logic lw_stall;

   // The freeze is combinational so the missing access stops the pipe in the
   // very cycle the miss is seen, not one cycle late.
   assign miss_start = (state == RUN) && memReqM && !cacheHitM;
   assign freeze     = miss_start || ((state == MISS) && !memReadyM);

   assign lw_stall = tag_e.dst.is_load && (tag_e.dst.rd != 5'd0) &&
                     ((tag_e.dst.rd == rs1D) || (tag_e.dst.rd == rs2D));

   // Miss FSM. A memReadyM pulse in RUN has no transition and is dropped.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= RUN;
      end else begin
         case (state)
            RUN:     if (miss_start) state <= MISS;
            MISS:    if (memReadyM)  state <= RUN;
            default: state <= RUN;
         endcase
      end
   end

   // Shadow tags advance only when unfrozen; a flushE turns E into a bubble.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tag_e <= '0;
         tag_m <= '0;
         tag_w <= '0;
      end else if (!freeze) begin
         tag_e <= flushE ? '0 : {rs1D, rs2D, rdD, regWriteD, isLoadD};
         tag_m <= tag_e.dst;
         tag_w <= tag_m;
      end
   end

   assign forwardAE = fwd_select(tag_e.rs1, tag_m, tag_w);
   assign forwardBE = fwd_select(tag_e.rs2, tag_m, tag_w);

   // Reset gates the controls directly so they read zero while rst is high,
   // even if a stale miss or branch is still being driven.
   // NOTE: every output gets a default first so no path can infer a latch.
   always_comb begin
      stallF = 1'b0;
      stallD = 1'b0;
      stallE = 1'b0;
      stallM = 1'b0;
      flushD = 1'b0;
      flushE = 1'b0;
      if (rst) begin
         // all controls held low
      end else if (freeze) begin
         // Freeze outranks branch and load-use; both are re-evaluated once
         // the pipeline is released.
         stallF = 1'b1;
         stallD = 1'b1;
         stallE = 1'b1;
         stallM = 1'b1;
      end else begin
         stallF = lw_stall && !branchTakenE;
         stallD = lw_stall && !branchTakenE;
         flushD = branchTakenE;
         flushE = lw_stall || branchTakenE;
      end
   end

   // The load flag only matters in E; M/W keep it for completeness of the tag.
   logic unused_load_flags;
   assign unused_load_flags = tag_m.is_load ^ tag_w.is_load;

`ifdef HAZARD_PERF_EN
   hazard_perf u_perf (
      .clk          (clk),
      .rst          (rst),
      .stall_f      (stallF),
      .flush_any    (flushD || flushE),
      .in_miss      (state == MISS),
      .stall_cycles (stallCycles),
      .flush_count  (flushCount),
      .miss_cycles  (missCycles)
   );
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// tb_hazard_ctrl
// Directed bench for hazard_ctrl. Each step drives the decode/EX/MEM inputs
// just after a rising edge, queues the outputs expected for that cycle, and
// compares them on the following falling edge. Define HAZARD_PERF_EN to also
// check the performance counters.
// ----------------------------------------------------------------------------
module tb_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] rs1D, rs2D, rdD;
   logic       regWriteD, isLoadD, branchTakenE;
   logic       memReqM, cacheHitM, memReadyM;
   logic [1:0] forwardAE, forwardBE;
   logic       stallF, stallD, stallE, stallM, flushD, flushE;
`ifdef HAZARD_PERF_EN
   logic [31:0] stallCycles, flushCount, missCycles;
`endif

   always #5 clk = ~clk;

   hazard_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .rs1D         (rs1D),
      .rs2D         (rs2D),
      .rdD          (rdD),
      .regWriteD    (regWriteD),
      .isLoadD      (isLoadD),
      .branchTakenE (branchTakenE),
      .memReqM      (memReqM),
      .cacheHitM    (cacheHitM),
      .memReadyM    (memReadyM),
      .forwardAE    (forwardAE),
      .forwardBE    (forwardBE),
      .stallF       (stallF),
      .stallD       (stallD),
      .stallE       (stallE),
      .stallM       (stallM),
      .flushD       (flushD),
      .flushE       (flushE)
`ifdef HAZARD_PERF_EN
      ,
      .stallCycles  (stallCycles),
      .flushCount   (flushCount),
      .missCycles   (missCycles)
`endif
   );

   // control vector order: {stallF, stallD, stallE, stallM, flushD, flushE}
   localparam logic [5:0] CTL_NONE = 6'b000000;
   localparam logic [5:0] CTL_LU   = 6'b110001;
   localparam logic [5:0] CTL_BR   = 6'b000011;
   localparam logic [5:0] CTL_FRZ  = 6'b111100;

   typedef struct {
      string      tag;
      logic [1:0] fa;
      logic [1:0] fb;
      logic [5:0] ctl;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic expect_out(input string tag, input logic [1:0] fa,
                             input logic [1:0] fb, input logic [5:0] ctl);
      exp_t e;
      e.tag = tag;
      e.fa  = fa;
      e.fb  = fb;
      e.ctl = ctl;
      sb.push_back(e);
   endtask

   task automatic compare_queued();
      exp_t e;
      @(negedge clk);
      while (sb.size() > 0) begin
         e = sb.pop_front();
         check({e.tag, ".fwdA"}, 32'(forwardAE), 32'(e.fa));
         check({e.tag, ".fwdB"}, 32'(forwardBE), 32'(e.fb));
         check({e.tag, ".ctl"},
               32'({stallF, stallD, stallE, stallM, flushD, flushE}), 32'(e.ctl));
      end
   endtask

   task automatic cyc_check(input string tag, input logic [1:0] fa,
                            input logic [1:0] fb, input logic [5:0] ctl);
      expect_out(tag, fa, fb, ctl);
      compare_queued();
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_d(input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic we, input logic ld);
      rs1D      = rs1;
      rs2D      = rs2;
      rdD       = rd;
      regWriteD = we;
      isLoadD   = ld;
   endtask

   task automatic nops(input int n);
      for (int i = 0; i < n; i++) begin
         step();
         set_d(5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      end
   endtask

   initial begin
      rst          = 1'b1;
      set_d(5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      branchTakenE = 1'b0;
      memReqM      = 1'b0;
      cacheHitM    = 1'b1;
      memReadyM    = 1'b0;

      // Reset: controls stay low even with a taken branch presented.
      #1 branchTakenE = 1'b1;
      cyc_check("reset", 2'b00, 2'b00, CTL_NONE);
      step();
      rst          = 1'b0;
      branchTakenE = 1'b0;
      nops(3);

      // MEM forwarding: add x5 ; add x6,x5,x5
      step(); set_d(5'd1, 5'd2, 5'd5, 1'b1, 1'b0);
      cyc_check("memfwd.d", 2'b00, 2'b00, CTL_NONE);
      step(); set_d(5'd5, 5'd5, 5'd6, 1'b1, 1'b0);
      cyc_check("memfwd.pre", 2'b00, 2'b00, CTL_NONE);
      step(); set_d(5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      cyc_check("memfwd", 2'b10, 2'b10, CTL_NONE);
      nops(3);

      // WB forwarding: add x5 ; add x9,x1,x2 ; add x10,x5,x3
      step(); set_d(5'd1, 5'd2, 5'd5, 1'b1, 1'b0);
      step(); set_d(5'd1, 5'd2, 5'd9, 1'b1, 1'b0);
      step(); set_d(5'd5, 5'd3, 5'd10, 1'b1, 1'b0);
      step(); set_d(5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      cyc_check("wbfwd", 2'b01, 2'b00, CTL_NONE);
      nops(3);

      // Writer to x0 is never forwarded from MEM or WB.
      step(); set_d(5'd1, 5'd2, 5'd0, 1'b1, 1'b0);
      step(); set_d(5'd0, 5'd0, 5'd4, 1'b1, 1'b0);
      step(); set_d(5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      cyc_check("x0.mem", 2'b00, 2'b00, CTL_NONE);
      step();
      cyc_check("x0.wb", 2'b00, 2'b00, CTL_NONE);
      nops(3);

      // Load-use: lw x7 ; add x8,x7,x1
      step(); set_d(5'd2, 5'd0, 5'd7, 1'b1, 1'b1);
      cyc_check("lu.pre", 2'b00, 2'b00, CTL_NONE);
      step(); set_d(5'd7, 5'd1, 5'd8, 1'b1, 1'b0);
      cyc_check("lu.stall", 2'b00, 2'b00, CTL_LU);
      step();  // decode held, bubble now in E
      cyc_check("lu.bubble", 2'b00, 2'b00, CTL_NONE);
      step(); set_d(5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      cyc_check("lu.fwd", 2'b01, 2'b00, CTL_NONE);
      nops(3);

      // Taken branch together with a load-use hazard: branch wins.
      step(); set_d(5'd2, 5'd0, 5'd7, 1'b1, 1'b1);
      step(); set_d(5'd7, 5'd1, 5'd8, 1'b1, 1'b0); branchTakenE = 1'b1;
      cyc_check("br_lu", 2'b00, 2'b00, CTL_BR);
      step(); set_d(5'd0, 5'd0, 5'd0, 1'b0, 1'b0); branchTakenE = 1'b0;
      cyc_check("br_after", 2'b00, 2'b00, CTL_NONE);
      nops(3);

      // memReadyM pulse in RUN is ignored.
      step(); memReadyM = 1'b1;
      cyc_check("rdy_run", 2'b00, 2'b00, CTL_NONE);
      step(); memReadyM = 1'b0;
      cyc_check("rdy_run.next", 2'b00, 2'b00, CTL_NONE);
      nops(3);

      // Cache miss at cycle 10 with a concurrent taken branch, ready at 25.
      step(); set_d(5'd1, 5'd2, 5'd5, 1'b1, 1'b0);
      step(); set_d(5'd5, 5'd5, 5'd6, 1'b1, 1'b0);
      step(); set_d(5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      memReqM = 1'b1; cacheHitM = 1'b0; branchTakenE = 1'b1;
      cyc_check("miss.c10", 2'b10, 2'b10, CTL_FRZ);
      for (int c = 11; c <= 24; c++) begin
         step();
         cyc_check($sformatf("miss.c%0d", c), 2'b10, 2'b10, CTL_FRZ);
      end
      step(); memReadyM = 1'b1; branchTakenE = 1'b0;
      cyc_check("miss.c25", 2'b10, 2'b10, CTL_NONE);
      step(); memReqM = 1'b0; cacheHitM = 1'b1; memReadyM = 1'b0;
      cyc_check("miss.after", 2'b00, 2'b00, CTL_NONE);
`ifdef HAZARD_PERF_EN
      check("perf.missCycles", missCycles, 32'd15);
      check("perf.stallCycles", stallCycles, 32'd16);
      check("perf.flushCount", flushCount, 32'd2);
`endif
      nops(3);

      // Reset asserted at cycle 15 of a second miss.
      step(); set_d(5'd1, 5'd2, 5'd5, 1'b1, 1'b0);
      step(); set_d(5'd5, 5'd5, 5'd6, 1'b1, 1'b0);
      step(); set_d(5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      memReqM = 1'b1; cacheHitM = 1'b0;
      cyc_check("miss2.c10", 2'b10, 2'b10, CTL_FRZ);
      for (int c = 11; c <= 14; c++) step();
      step(); rst = 1'b1;
      cyc_check("rst_miss", 2'b00, 2'b00, CTL_NONE);
      step(); rst = 1'b0; memReqM = 1'b0; cacheHitM = 1'b1;
      cyc_check("rst_run", 2'b00, 2'b00, CTL_NONE);
`ifdef HAZARD_PERF_EN
      check("perf.miss_after_rst", missCycles, 32'd0);
`endif
      step();
      cyc_check("rst_run.next", 2'b00, 2'b00, CTL_NONE);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  pipeline clock, rising edge.
REQ-002 SHALL have ports: rst  in  1  asynchronous, active-high reset.
REQ-003 SHALL have ports: rs1D, rs2D  in  5 each  decode-stage source registers.
REQ-004 SHALL have ports: rdD  in  5; regWriteD  in  1; isLoadD  in  1  decode-stage destination, write-enable and load flag.
REQ-005 SHALL have ports: branchTakenE  in  1  EX-stage branch decision.
REQ-006 SHALL have ports: memReqM  in  1; cacheHitM  in  1; memReadyM  in  1  MEM-stage data-cache access, hit and refill-done.
REQ-007 SHALL have ports: forwardAE, forwardBE  out  2 each  EX operand select: 00 register, 10 MEM, 01 WB.
REQ-008 SHALL have ports: stallF, stallD, stallE, stallM  out  1 each; flushD, flushE  out  1 each.

Function
REQ-009 SHALL hold shadow stage tags {rs1, rs2, rd, regWrite, isLoad} for E, plus {rd, regWrite, isLoad} for M and W.
REQ-010 Each unfrozen clock SHALL shift tags: E<=D, or all-zero if flushE; M<=E; W<=M.
REQ-011 forwardAE SHALL be 10 when regWriteM && rdM!=0 && rdM==rs1E; else 01 when regWriteW && rdW!=0 && rdW==rs1E; else 00. forwardBE SHALL use the same rule on rs2E.
REQ-012 Forward selects SHALL be combinational from registered tags: zero added latency.
REQ-013 lwStall SHALL assert when isLoadE && rdE!=0 && (rdE==rs1D || rdE==rs2D).
REQ-014 FSM states SHALL be RUN and MISS.
REQ-015 RUN->MISS SHALL occur when memReqM && !cacheHitM. MISS->RUN SHALL occur on memReadyM.
REQ-016 In RUN: stallF=stallD=lwStall && !branchTakenE; flushD=branchTakenE; flushE=lwStall||branchTakenE; stallE=stallM=0.
REQ-017 The miss condition SHALL freeze the pipeline combinationally in the same cycle, and in every MISS cycle until memReadyM is sampled: stallF/D/E/M=1, flushD/E=0, shadow tags held, branchTakenE and lwStall ignored.
REQ-018 In the memReadyM cycle, stalls SHALL be released; the next edge advances tags normally.
REQ-019 Simultaneous miss and taken branch SHALL give the freeze priority; the branch is re-evaluated after release.
REQ-020 A memReadyM pulse while in RUN SHALL be ignored.

Reset
REQ-021 rst SHALL force, asynchronously: FSM=RUN, all tags=0, forwardAE/BE=00, all stall/flush outputs=0.
REQ-022 rst asserted in MISS SHALL abandon the miss; the pipeline restarts unfrozen.

Configuration
REQ-023 With HAZARD_PERF_EN defined, the block SHALL add outputs stallCycles, flushCount and missCycles, each out 32.
REQ-024 The counters SHALL be reset to 0 and wrap at 2^32. They SHALL count, respectively: cycles with stallF=1; cycles with flushD||flushE; cycles in MISS.
REQ-025 Without HAZARD_PERF_EN, these ports and their logic SHALL be absent, with identical remaining behaviour.

Structure
REQ-026 The shared package hazard_pkg SHALL hold:
- fwd_sel_t (FWD_REG=00, FWD_WB=01, FWD_MEM=10)
- hz_state_t (RUN, MISS)
- the stage-tag struct
REQ-027 Perf counters SHALL live in sub-module hazard_perf, instantiated only under HAZARD_PERF_EN.

Verification
REQ-028 Scenario — MEM forwarding: add x5 in E, then add x6,x5,x5 in D → next cycle forwardAE=forwardBE=10.
REQ-029 Scenario — WB forwarding: x5 writer followed by one independent instruction, then a reader of x5 → forwardAE=01. Writer to x0 → 00.
REQ-030 Scenario — load-use: lw x7 in E, add x8,x7,x1 in D → one cycle of stallF=stallD=flushE=1; then forwardAE=01.
REQ-031 Scenario — branch taken with a concurrent load-use hazard: flushD=flushE=1, stallF=0.
REQ-032 Scenario — cache miss: memReqM=1, cacheHitM=0 at cycle 10, memReadyM at cycle 25 → all stalls asserted from cycle 10 through 24, released at 25. Under HAZARD_PERF_EN, missCycles=15.
REQ-033 Scenario — reset during MISS: rst at cycle 15 → all outputs 0 immediately; after release, state RUN.
